matrix_frame_arbiter: RTL
=========================

MATRIX_FRAME_ARBITER -- requirements
Module: matrix_frame_arbiter

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 11'd640, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 11'd480, active lines per frame.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 11'd650: guard cycles after the granted frame ends, covering last-row extension of the downstream 3x3 window generator.
REQ-004 SHALL have the following ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s0_vsync, s0_href  in  1  source 0 framing.
- s0_gray  in  8  source 0 pixel.
- s1_vsync, s1_href  in  1  source 1 framing.
- s1_gray  in  8  source 1 pixel.
- win_vsync  in  1  downstream window generator output vsync (busy indication).
- m_vsync, m_href  out  1  arbitrated framing to the window generator.
- m_gray  out  8  arbitrated pixel.
- grant  out  1  current owner (0 = s0, 1 = s1).
- busy  out  1  high in any state other than IDLE.
- drop0_cnt, drop1_cnt  out  8  skipped-frame counters.

Function
REQ-005 SHALL detect a frame request per source on the rising edge of sN_vsync (registered-input compare) and set pend[N]; pend[N] SHALL clear when that source's frame is granted and enters STREAM.
REQ-006 SHALL implement an FSM with states IDLE, ARM, STREAM, FLUSH.
REQ-007 IDLE -> ARM when any pend bit is set; grant SHALL select round-robin, preferring the source not served last; on a tie after reset, s0 wins.
REQ-008 ARM SHALL wait for the next rising edge of the granted source's vsync, then enter STREAM; a frame already in progress at grant time SHALL NOT be forwarded.
REQ-009 In STREAM, m_vsync, m_href and m_gray SHALL equal the granted source's signals delayed by exactly one clk (registered); the non-granted source SHALL be ignored.
REQ-010 STREAM -> FLUSH on the falling edge of the granted source's vsync.
REQ-011 In FLUSH, m_vsync, m_href and m_gray SHALL be 0; an 11-bit counter SHALL count FLUSH_CYCLES cycles. Exit to IDLE SHALL occur only when the count is done and win_vsync is 0; otherwise the block holds in FLUSH.
REQ-012 Outside STREAM, m_vsync, m_href and m_gray SHALL be 0 (no partial frames downstream).
REQ-013 A rising vsync on a source while the other source is granted (ARM, STREAM or FLUSH) SHALL increment that source's drop counter, saturating at 8'hFF; pend SHALL still be set.
REQ-014 Simultaneous rising edges on both sources in IDLE SHALL be resolved per REQ-007, and the loser SHALL remain pending.
REQ-015 If the granted source's href is high for more than IMG_HDISP cycles, or more than IMG_VDISP lines occur, the block SHALL still forward the frame unchanged; no truncation is performed.

Reset
REQ-016 On rst_n low, state SHALL be IDLE; grant, busy, m_vsync, m_href, m_gray, pend, the flush counter and both drop counters SHALL be 0.
REQ-017 Reset asserted mid-STREAM SHALL force m_href and m_vsync low asynchronously; after release, the block SHALL not resume the interrupted frame.

Configuration
REQ-018 Macro FRAME_DROP_CNT_EN defined: drop0_cnt and drop1_cnt SHALL behave per REQ-013.
REQ-019 Macro FRAME_DROP_CNT_EN undefined: no counter logic SHALL be present, and drop0_cnt and drop1_cnt SHALL be tied to 8'h00.

Verification
REQ-020 s0 sends one 640x480 frame, s1 idle -> the frame appears on the m_* ports 1 cycle late, grant=0, busy falls FLUSH_CYCLES cycles after s0_vsync falls.
REQ-021 s0 and s1 vsync rise on the same cycle after reset -> s0 is forwarded first, then s1's next frame; grant sequence is 0, 1.
REQ-022 s1 frame starts while s0 is in STREAM -> drop1_cnt = 1, and no s1 pixel appears until the next s1 vsync after the FLUSH exit.
REQ-023 win_vsync held high 100 cycles beyond the FLUSH count -> state stays FLUSH, m_vsync = 0, exit on the cycle after win_vsync falls.
REQ-024 rst_n pulsed low in mid-line of STREAM -> m_href = 0 immediately, state IDLE, counters 0.
REQ-025 Build without FRAME_DROP_CNT_EN and repeat REQ-022 -> drop1_cnt stays 8'h00.

Source files
------------

// File: rtl/matrix_frame_arbiter.sv
// Two-source frame arbiter feeding a downstream 3x3 window generator.
// Optional: define FRAME_DROP_CNT_EN to build the per-source skipped-frame counters.
module matrix_frame_arbiter #(
  parameter logic [10:0] IMG_HDISP    = 11'd640,
  parameter logic [10:0] IMG_VDISP    = 11'd480,
  parameter logic [10:0] FLUSH_CYCLES = 11'd650
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_vsync,
  input  logic       s0_href,
  input  logic [7:0] s0_gray,
  input  logic       s1_vsync,
  input  logic       s1_href,
  input  logic [7:0] s1_gray,
  input  logic       win_vsync,
  output logic       m_vsync,
  output logic       m_href,
  output logic [7:0] m_gray,
  output logic       grant,
  output logic       busy,
  output logic [7:0] drop0_cnt,
  output logic [7:0] drop1_cnt
);

  // Frame geometry is informational only: oversized frames pass through untrimmed.
  localparam logic [21:0] unused_geometry = {IMG_HDISP, IMG_VDISP};

  typedef enum logic [1:0] {IDLE, ARM, STREAM, FLUSH} state_t;

  state_t      state, state_nx;
  logic        s0_vsync_q, s1_vsync_q;
  logic [1:0]  rise;
  logic [1:0]  pend, pend_nx, req;
  logic        grant_nx;
  logic        last_served;
  logic        stream_en;
  logic        enter_stream;
  logic        sel_vsync, sel_href, sel_vsync_q, fall_sel;
  logic [7:0]  sel_gray;
  logic [10:0] flush_cnt;
  logic        flush_done;

  // vsync history resets high so a frame interrupted by reset is never seen as a new rise
  assign rise[0] = s0_vsync & ~s0_vsync_q;
  assign rise[1] = s1_vsync & ~s1_vsync_q;
  assign req     = pend | rise;
  assign busy    = (state != IDLE);

  assign sel_vsync   = grant_nx ? s1_vsync   : s0_vsync;
  assign sel_href    = grant_nx ? s1_href    : s0_href;
  assign sel_gray    = grant_nx ? s1_gray    : s0_gray;
  assign sel_vsync_q = grant_nx ? s1_vsync_q : s0_vsync_q;
  assign fall_sel    = ~sel_vsync & sel_vsync_q;
  assign flush_done  = (flush_cnt == FLUSH_CYCLES - 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A grant that lands on the winner's own vsync edge skips ARM and streams that frame at once.
  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    stream_en = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx = (req == 2'b11) ? ~last_served : req[1];
          if (rise[grant_nx]) begin
            state_nx  = STREAM;
            stream_en = 1'b1;
          end else begin
            state_nx = ARM;
          end
        end
      end
      ARM: begin
        if (rise[grant]) begin
          state_nx  = STREAM;
          stream_en = 1'b1;
        end
      end
      STREAM: begin
        stream_en = 1'b1;
        if (fall_sel) state_nx = FLUSH;
      end
      FLUSH: begin
        if (flush_done && !win_vsync) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign enter_stream = (state != STREAM) && (state_nx == STREAM);

  always_comb begin
    pend_nx = pend | rise;
    if (enter_stream) pend_nx[grant_nx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= 1'b0;
      last_served <= 1'b1;
      pend        <= 2'b00;
      s0_vsync_q  <= 1'b1;
      s1_vsync_q  <= 1'b1;
      flush_cnt   <= 11'd0;
      m_vsync     <= 1'b0;
      m_href      <= 1'b0;
      m_gray      <= 8'h00;
    end else begin
      grant      <= grant_nx;
      pend       <= pend_nx;
      s0_vsync_q <= s0_vsync;
      s1_vsync_q <= s1_vsync;
      if (enter_stream) last_served <= grant_nx;
      if (state != FLUSH)   flush_cnt <= 11'd0;
      else if (!flush_done) flush_cnt <= flush_cnt + 11'd1;
      m_vsync <= stream_en & sel_vsync;
      m_href  <= stream_en & sel_href;
      m_gray  <= stream_en ? sel_gray : 8'h00;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic [1:0] drop_inc;
  logic [7:0] drop0_q, drop1_q;

  assign drop_inc[0] = rise[0] & busy & grant;
  assign drop_inc[1] = rise[1] & busy & ~grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop0_q <= 8'h00;
      drop1_q <= 8'h00;
    end else begin
      if (drop_inc[0] && drop0_q != 8'hFF) drop0_q <= drop0_q + 8'h01;
      if (drop_inc[1] && drop1_q != 8'hFF) drop1_q <= drop1_q + 8'h01;
    end
  end

  assign drop0_cnt = drop0_q;
  assign drop1_cnt = drop1_q;
`else
  assign drop0_cnt = 8'h00;
  assign drop1_cnt = 8'h00;
`endif

endmodule
